// File: rtl/rv32i_pipe_ctrl_if.sv
// rv32i_pipe_ctrl_if: pipeline-side signals of the sequencing controller
//   master: the pipeline (drives hazard/event inputs, consumes control outputs)
//   slave:  the controller
interface rv32i_pipe_ctrl_if #(parameter int REG_BITS = 5);
  logic                fetch_valid_i;
  logic [REG_BITS-1:0] dec_rs1_i;
  logic [REG_BITS-1:0] dec_rs2_i;
  logic [1:0]          dec_rs_used_i;
  logic                ex_valid_i;
  logic                ex_is_load_i;
  logic [REG_BITS-1:0] ex_rd_i;
  logic                jal_i;
  logic                redirect_i;
  logic                mem_req_i;
  logic                mem_done_i;
  logic                decode_ready_o;
  logic                decode_clear_o;
  logic                execute_clear_o;
  logic                fetch_stall_o;
  logic [1:0]          pc_sel_o;
  logic [1:0]          state_o;
  logic [15:0]         stall_cycles_o;
  modport master (
    output fetch_valid_i, dec_rs1_i, dec_rs2_i, dec_rs_used_i, ex_valid_i, ex_is_load_i,
           ex_rd_i, jal_i, redirect_i, mem_req_i, mem_done_i,
    input  decode_ready_o, decode_clear_o, execute_clear_o, fetch_stall_o, pc_sel_o,
           state_o, stall_cycles_o
  );
  modport slave (
    input  fetch_valid_i, dec_rs1_i, dec_rs2_i, dec_rs_used_i, ex_valid_i, ex_is_load_i,
           ex_rd_i, jal_i, redirect_i, mem_req_i, mem_done_i,
    output decode_ready_o, decode_clear_o, execute_clear_o, fetch_stall_o, pc_sel_o,
           state_o, stall_cycles_o
  );
endinterface

// File: rtl/rv32i_pipe_ctrl.sv
// rv32i_pipe_ctrl: decode/fetch sequencing for load-use, memory waits and redirects
//   clk_i, rst_n_i: clock and asynchronous active-low reset
//   bus (slave): hazard/event inputs in, stall/clear/pc-select controls and stall counter out
module rv32i_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_BITS     = 5
) (
  input logic              clk_i,
  input logic              rst_n_i,
  rv32i_pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'b00, LOAD_WAIT = 2'b01, MEM_WAIT = 2'b10, FLUSH = 2'b11} state_t;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  state_t              state, state_nx;
  logic [2:0]          fcnt, fcnt_nx;
  logic                pend, pend_nx;
  logic [15:0]         scnt;
  logic [REG_BITS-1:0] rd;
  logic                hazard, mem_block, redir, done;
  logic                ready, dclr, eclr, stall;
  logic [1:0]          pc_sel;
  assign rd        = bus.ex_rd_i;
  assign redir     = bus.redirect_i;
  assign done      = bus.mem_done_i;
  assign mem_block = bus.mem_req_i & ~done;
  assign hazard    = bus.ex_valid_i & bus.ex_is_load_i & (rd != '0) &
                     ((bus.dec_rs_used_i[0] & (bus.dec_rs1_i == rd)) |
                      (bus.dec_rs_used_i[1] & (bus.dec_rs2_i == rd)));
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    pend_nx  = pend;
    ready    = 1'b0;
    dclr     = 1'b0;
    eclr     = 1'b0;
    stall    = 1'b0;
    pc_sel   = 2'b00;
    case (state)
      RUN: begin
        if (redir) begin
          pc_sel   = 2'b10;
          dclr     = 1'b1;
          eclr     = 1'b1;
          fcnt_nx  = FLUSH_LOAD;
          state_nx = FLUSH;
        end else if (mem_block) begin
          stall    = 1'b1;
          state_nx = MEM_WAIT;
        end else if (hazard) begin
          stall    = 1'b1;
          eclr     = 1'b1;
          state_nx = LOAD_WAIT;
        end else if (bus.jal_i) begin
          pc_sel = 2'b01;
          dclr   = 1'b1;
        end else begin
          ready = bus.fetch_valid_i;
        end
      end
      LOAD_WAIT: begin
        if (redir) begin
          pc_sel   = 2'b10;
          dclr     = 1'b1;
          eclr     = 1'b1;
          fcnt_nx  = FLUSH_LOAD;
          state_nx = FLUSH;
        end else begin
          stall    = 1'b1;
          eclr     = 1'b1;
          ready    = done & bus.fetch_valid_i;
          state_nx = done ? RUN : LOAD_WAIT;
        end
      end
      MEM_WAIT: begin
        // a redirect seen while memory is busy is deferred until the access completes
        if (done && (pend || redir)) begin
          pc_sel   = 2'b10;
          dclr     = 1'b1;
          eclr     = 1'b1;
          fcnt_nx  = FLUSH_LOAD;
          pend_nx  = 1'b0;
          state_nx = FLUSH;
        end else begin
          stall    = 1'b1;
          pend_nx  = pend | redir;
          state_nx = done ? RUN : MEM_WAIT;
        end
      end
      FLUSH: begin
        dclr     = 1'b1;
        eclr     = 1'b1;
        stall    = mem_block;
        pc_sel   = redir ? 2'b10 : 2'b00;
        fcnt_nx  = redir ? FLUSH_LOAD : mem_block ? fcnt : fcnt - 3'd1;
        state_nx = (!redir && !mem_block && fcnt <= 3'd1) ? RUN : FLUSH;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      fcnt  <= '0;
      pend  <= 1'b0;
      scnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      pend  <= pend_nx;
      scnt  <= scnt + 16'(stall && scnt != 16'hffff);
    end
  end
  // reset overrides the combinational controls so the pipeline is frozen and squashed
  assign bus.decode_ready_o  = rst_n_i & ready;
  assign bus.decode_clear_o  = ~rst_n_i | dclr;
  assign bus.execute_clear_o = ~rst_n_i | eclr;
  assign bus.fetch_stall_o   = ~rst_n_i | stall;
  assign bus.pc_sel_o        = rst_n_i ? pc_sel : 2'b00;
  assign bus.state_o         = state;
  assign bus.stall_cycles_o  = scnt;
endmodule
